// File: rtl/single_cycle_pkg.sv
// Package: single_cycle_pkg
// Purpose: Shared constants for the single-cycle datapath. It holds the ALU
//          operation encodings and the bit positions of the instruction fields.
//          Instruction layout: [31:26] opcode (unused), [25:21] rs, [20:16] rt,
//          [15:0] immediate.
package single_cycle_pkg;

    // ALU operation select encodings
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_NONE = 3'b101;  // reserved, result is 0
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // Instruction field positions
    localparam int REG_BITS = 5;
    localparam int RS_LSB   = 21;
    localparam int RT_LSB   = 16;
    localparam int IMM_BITS = 16;

endpackage

// File: rtl/single_cycle_processor_units.sv
// Sub-modules of single_cycle_processor:
//   pc_reg       : program counter register, synchronous active-high reset
//                  ports: clk, rst, pc_next -> pc
//   pc_increment : pc_next = pc + 1, wraps at 2**PCW
//                  ports: pc -> pc_next
//   instr_mem    : instruction ROM (imem_mem), combinational read
//                  ports: addr -> instr
//   reg_file     : register file (rf_mem), two combinational read ports and
//                  one synchronous write port; register 0 reads as zero
//                  ports: clk, we, ra1, ra2, wa, wd -> rd1, rd2
//   data_mem     : data RAM (dmem_mem), combinational read, synchronous write
//                  ports: clk, we, addr, wd -> rd
//   sign_extend  : 16-bit immediate to width bits
//                  ports: imm -> ext
//   alu          : combinational ALU, ops from single_cycle_pkg
//                  ports: op, a, b -> result

module pc_reg #(
    parameter int PCW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [PCW-1:0] pc_next,
    output logic [PCW-1:0] pc
);
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its inputs, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end
endmodule

module pc_increment #(
    parameter int PCW = 5
) (
    input  logic [PCW-1:0] pc,
    output logic [PCW-1:0] pc_next
);
    // Natural modulo-2**PCW wrap; no terminal-count logic needed.
    assign pc_next = pc + PCW'(1);
endmodule

module instr_mem #(
    parameter int width      = 32,
    parameter int wordLength = 32,
    parameter int AW         = 5
) (
    input  logic [AW-1:0]    addr,
    output logic [width-1:0] instr
);
    // Contents are loaded from outside (backdoor); there is no write port.
    logic [width-1:0] imem_mem [wordLength];

    assign instr = imem_mem[addr];
endmodule

module reg_file #(
    parameter int width      = 32,
    parameter int wordLength = 32,
    parameter int AW         = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    wa,
    input  logic [width-1:0] wd,
    output logic [width-1:0] rd1,
    output logic [width-1:0] rd2
);
    logic [width-1:0] rf_mem [wordLength];

    // NOTE: the storage array is deliberately kept out of reset so it maps
    // onto plain RAM/regfile cells; only the PC is cleared by rst.
    always_ff @(posedge clk) begin
        if (we && (wa != '0)) begin
            rf_mem[wa] <= wd;
        end
    end

    // Register 0 is hardwired to zero on the read side, whatever the array holds.
    assign rd1 = (ra1 == '0) ? '0 : rf_mem[ra1];
    assign rd2 = (ra2 == '0) ? '0 : rf_mem[ra2];
endmodule

module data_mem #(
    parameter int width      = 32,
    parameter int wordLength = 32,
    parameter int AW         = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [width-1:0] wd,
    output logic [width-1:0] rd
);
    logic [width-1:0] dmem_mem [wordLength];

    always_ff @(posedge clk) begin
        if (we) begin
            dmem_mem[addr] <= wd;
        end
    end

    // Read is combinational, so a same-cycle load sees the pre-write value.
    assign rd = dmem_mem[addr];
endmodule

module sign_extend #(
    parameter int width = 32
) (
    input  logic [15:0]      imm,
    output logic [width-1:0] ext
);
    assign ext = {{(width - 16){imm[15]}}, imm};
endmodule

module alu
    import single_cycle_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [2:0]       op,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] result
);
    // NOTE: result gets a default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        result = '0;
        case (op)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_NONE: result = '0;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(width - 1){1'b0}}, ($signed(a) < $signed(b))};
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/single_cycle_processor.sv
// Module: single_cycle_processor
// Purpose: Externally controlled single-cycle MIPS-style datapath. Each clock:
//          fetch imem[PC], read rs/rt, compute ALU(rf[rs], sext(imm)), access
//          data memory at the ALU result, optionally write the load data back
//          to rf[rt], and advance PC by one.
// Ports:
//   clk       in   1      clock, all state updates on posedge
//   rst       in   1      synchronous active-high reset, clears PC only
//   RegWrite  in   1      register file write enable (rf[rt] <= ReadD)
//   MemWrite  in   1      data memory write enable (dmem[addr] <= WriteMem)
//   ALUop     in   3      ALU operation select
//   RD1       out  width  rf[rs], ALU operand A
//   RD2       out  width  sign-extended immediate, ALU operand B
//   ALUOut    out  width  ALU result, also the data memory address
//   ReadD     out  width  data memory read data
//   WriteMem  out  width  rf[rt], data memory write data
module single_cycle_processor
    import single_cycle_pkg::*;
#(
    parameter int width      = 32,
    parameter int wordLength = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWrite,
    input  logic             MemWrite,
    input  logic [2:0]       ALUop,
    output logic [width-1:0] RD1,
    output logic [width-1:0] RD2,
    output logic [width-1:0] ALUOut,
    output logic [width-1:0] ReadD,
    output logic [width-1:0] WriteMem
);
    localparam int PCW = $clog2(width);
    localparam int AW  = $clog2(wordLength);

    logic [PCW-1:0]      pc;
    logic [PCW-1:0]      pc_next;
    logic [width-1:0]    instr;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic [IMM_BITS-1:0] imm;
    logic                unused_bits;

    assign rs  = instr[RS_LSB +: REG_BITS];
    assign rt  = instr[RT_LSB +: REG_BITS];
    assign imm = instr[IMM_BITS-1:0];

    // Opcode field has no decoder, and the data memory only sees the low
    // address bits so accesses wrap around the array.
    assign unused_bits = ^{instr[width-1:RS_LSB+REG_BITS], ALUOut[width-1:AW]};

    pc_reg #(.PCW(PCW)) u_pc (
        .clk     (clk),
        .rst     (rst),
        .pc_next (pc_next),
        .pc      (pc)
    );

    pc_increment #(.PCW(PCW)) u_inc (
        .pc      (pc),
        .pc_next (pc_next)
    );

    instr_mem #(.width(width), .wordLength(wordLength), .AW(PCW)) u_imem (
        .addr  (pc),
        .instr (instr)
    );

    // rt is both the second read port and the write-back destination.
    reg_file #(.width(width), .wordLength(wordLength), .AW(REG_BITS)) u_rf (
        .clk (clk),
        .we  (RegWrite),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (rt),
        .wd  (ReadD),
        .rd1 (RD1),
        .rd2 (WriteMem)
    );

    sign_extend #(.width(width)) u_sext (
        .imm (imm),
        .ext (RD2)
    );

    alu #(.width(width)) u_alu (
        .op     (ALUop),
        .a      (RD1),
        .b      (RD2),
        .result (ALUOut)
    );

    data_mem #(.width(width), .wordLength(wordLength), .AW(AW)) u_dmem (
        .clk  (clk),
        .we   (MemWrite),
        .addr (ALUOut[AW-1:0]),
        .wd   (WriteMem),
        .rd   (ReadD)
    );

endmodule

// File: tb/tb_single_cycle_processor.sv
// Bench for single_cycle_processor: directed sequences, a table of ALU
// vectors, and a randomized run checked against a behavioural model that
// tracks PC, register file and data memory as plain arrays.
module tb_single_cycle_processor;
    import single_cycle_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite;
    logic        MemWrite;
    logic [2:0]  ALUop;
    logic [31:0] RD1, RD2, ALUOut, ReadD, WriteMem;

    int n_vec = 0;
    int n_err = 0;

    single_cycle_processor #(.width(32), .wordLength(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .ALUop    (ALUop),
        .RD1      (RD1),
        .RD2      (RD2),
        .ALUOut   (ALUOut),
        .ReadD    (ReadD),
        .WriteMem (WriteMem)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_imem [32];
    logic [31:0] m_rf   [32];
    logic [31:0] m_dmem [32];
    int          m_pc;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [15:0] imm;
        logic [31:0] exp;
        string       name;
    } alu_vec_t;

    alu_vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a ^ b;
            3'b100:  return ~(a | b);
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Expected combinational outputs for the current model state and inputs.
    task automatic model_outputs(output logic [31:0] e_rd1, output logic [31:0] e_rd2,
                                 output logic [31:0] e_alu, output logic [31:0] e_rdd,
                                 output logic [31:0] e_wm, output int rt, output int addr);
        logic [31:0] instr;
        int rs;
        int simm;
        instr = m_imem[m_pc];
        rs    = int'(instr[25:21]);
        rt    = int'(instr[20:16]);
        simm  = int'($signed(instr[15:0]));
        e_rd1 = (rs == 0) ? 32'd0 : m_rf[rs];
        e_rd2 = simm;
        e_alu = ref_alu(ALUop, e_rd1, e_rd2);
        addr  = int'(e_alu % 32);
        e_rdd = m_dmem[addr];
        e_wm  = (rt == 0) ? 32'd0 : m_rf[rt];
    endtask

    task automatic check_model(input string tag);
        logic [31:0] e_rd1, e_rd2, e_alu, e_rdd, e_wm;
        int rt, addr;
        model_outputs(e_rd1, e_rd2, e_alu, e_rdd, e_wm, rt, addr);
        check({tag, ".RD1"}, RD1, e_rd1);
        check({tag, ".RD2"}, RD2, e_rd2);
        check({tag, ".ALUOut"}, ALUOut, e_alu);
        check({tag, ".ReadD"}, ReadD, e_rdd);
        check({tag, ".WriteMem"}, WriteMem, e_wm);
    endtask

    // Drive inputs (called at negedge) and let combinational logic settle.
    task automatic apply(input logic r, input logic rw, input logic mw, input logic [2:0] op);
        rst      = r;
        RegWrite = rw;
        MemWrite = mw;
        ALUop    = op;
        #1;
    endtask

    // One clock: advance the model with the pre-edge values, check PC, return at negedge.
    task automatic tick();
        logic [31:0] e_rd1, e_rd2, e_alu, e_rdd, e_wm;
        int rt, addr;
        model_outputs(e_rd1, e_rd2, e_alu, e_rdd, e_wm, rt, addr);
        @(posedge clk);
        if (RegWrite && rt != 0) m_rf[rt] = e_rdd;
        if (MemWrite) m_dmem[addr] = e_wm;
        m_pc = rst ? 0 : (m_pc + 1) % 32;
        #1;
        check("pc", 32'(dut.pc), m_pc);
        @(negedge clk);
    endtask

    // Backdoor preloads keep DUT memories and model in step.
    task automatic set_imem(input int i, input logic [31:0] v);
        dut.u_imem.imem_mem[i] <= v;
        m_imem[i] = v;
    endtask

    task automatic set_rf(input int i, input logic [31:0] v);
        dut.u_rf.rf_mem[i] <= v;
        m_rf[i] = v;
    endtask

    task automatic set_dmem(input int i, input logic [31:0] v);
        dut.u_dmem.dmem_mem[i] <= v;
        m_dmem[i] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] e_rd1, e_rd2, e_alu, e_rdd, e_wm;
        int rt, addr;

        vecs[0]  = '{ALU_AND,  32'h000000F0, 16'h000F, 32'h00000000, "alu.and"};
        vecs[1]  = '{ALU_OR,   32'h000000F0, 16'h000F, 32'h000000FF, "alu.or"};
        vecs[2]  = '{ALU_ADD,  32'h000000F0, 16'h000F, 32'h000000FF, "alu.add"};
        vecs[3]  = '{ALU_XOR,  32'h000000F0, 16'h000F, 32'h000000FF, "alu.xor"};
        vecs[4]  = '{ALU_NOR,  32'h000000F0, 16'h000F, 32'hFFFFFF00, "alu.nor"};
        vecs[5]  = '{ALU_NONE, 32'h000000F0, 16'h000F, 32'h00000000, "alu.op101"};
        vecs[6]  = '{ALU_SUB,  32'h000000F0, 16'h000F, 32'h000000E1, "alu.sub"};
        vecs[7]  = '{ALU_SLT,  32'h000000F0, 16'h000F, 32'h00000000, "alu.slt"};
        vecs[8]  = '{ALU_SLT,  32'hFFFFFFFF, 16'h0001, 32'h00000001, "alu.slt_neg"};
        vecs[9]  = '{ALU_SLT,  32'h80000000, 16'h7FFF, 32'h00000001, "alu.slt_min"};
        vecs[10] = '{ALU_SLT,  32'h00000005, 16'hFFFF, 32'h00000000, "alu.slt_signed"};
        vecs[11] = '{ALU_SUB,  32'h00000000, 16'h0001, 32'hFFFFFFFF, "alu.sub_wrap"};
        vecs[12] = '{ALU_ADD,  32'h7FFFFFFF, 16'h0001, 32'h80000000, "alu.add_ovf"};
        vecs[13] = '{ALU_AND,  32'hFFFFFFFF, 16'h8000, 32'hFFFF8000, "alu.and_sext"};
        vecs[14] = '{ALU_SUB,  32'h00000003, 16'hFFFF, 32'h00000004, "alu.sub_neg"};

        // 1. Reset with zeroed memories
        m_pc = 0;
        for (int i = 0; i < 32; i++) begin
            set_imem(i, 32'd0);
            set_rf(i, 32'd0);
            set_dmem(i, 32'd0);
        end
        rst = 1'b1; RegWrite = 1'b0; MemWrite = 1'b0; ALUop = ALU_AND;
        #1;
        tick();
        check("reset.RD1", RD1, 32'd0);
        check("reset.RD2", RD2, 32'd0);
        check("reset.ALUOut", ALUOut, 32'd0);
        check("reset.ReadD", ReadD, 32'd0);
        check("reset.WriteMem", WriteMem, 32'd0);

        // 2. Load at PC=0
        set_imem(0, 32'h8C220004);
        set_rf(1, 32'd8);
        set_dmem(12, 32'hDEADBEEF);
        apply(1'b0, 1'b1, 1'b0, ALU_ADD);
        check("load.RD1", RD1, 32'd8);
        check("load.RD2", RD2, 32'd4);
        check("load.ALUOut", ALUOut, 32'd12);
        check("load.ReadD", ReadD, 32'hDEADBEEF);
        check_model("load");
        tick();
        check("load.rf2", dut.u_rf.rf_mem[2], 32'hDEADBEEF);

        // 3. Negative immediate at PC=1
        set_imem(1, 32'h8C23FFFC);
        set_dmem(4, 32'h12345678);
        apply(1'b0, 1'b0, 1'b0, ALU_ADD);
        check("negimm.RD2", RD2, 32'hFFFFFFFC);
        check("negimm.ALUOut", ALUOut, 32'd4);
        check("negimm.ReadD", ReadD, 32'h12345678);
        tick();

        // 4. Store at PC=2
        set_imem(2, 32'hAC220000);
        set_rf(1, 32'd3);
        set_rf(2, 32'h55);
        apply(1'b0, 1'b0, 1'b1, ALU_ADD);
        check("store.WriteMem", WriteMem, 32'h55);
        check("store.ALUOut", ALUOut, 32'd3);
        tick();
        check("store.dmem3", dut.u_dmem.dmem_mem[3], 32'h55);

        // Load and store in the same cycle: rf captures the pre-write memory word
        set_imem(3, 32'h8C220000);
        set_rf(2, 32'hAAAA5555);
        apply(1'b0, 1'b1, 1'b1, ALU_ADD);
        check("rwsame.ReadD", ReadD, 32'h55);
        tick();
        check("rwsame.rf2", dut.u_rf.rf_mem[2], 32'h55);
        check("rwsame.dmem3", dut.u_dmem.dmem_mem[3], 32'hAAAA5555);

        // Register 0: nonzero backing word reads as 0, and a write to it is ignored
        set_rf(0, 32'h00001234);
        set_imem(4, 32'h8C200000);
        set_imem(5, 32'h8C000000);
        apply(1'b0, 1'b1, 1'b0, ALU_ADD);
        check("r0.WriteMem", WriteMem, 32'd0);
        tick();
        apply(1'b0, 1'b0, 1'b0, ALU_OR);
        check("r0.RD1", RD1, 32'd0);
        check("r0.WriteMem2", WriteMem, 32'd0);
        tick();

        // 5. ALU table, instruction rs=1 rt=0 placed at the current PC
        for (int i = 0; i < 15; i++) begin
            set_imem(m_pc, {6'h23, 5'd1, 5'd0, vecs[i].imm});
            set_rf(1, vecs[i].a);
            apply(1'b0, 1'b0, 1'b0, vecs[i].op);
            check(vecs[i].name, ALUOut, vecs[i].exp);
            check_model(vecs[i].name);
            tick();
        end

        // 6. PC wrap after 32 edges, then mid-run reset at PC=7 with a store pending
        apply(1'b1, 1'b0, 1'b0, ALU_AND);
        tick();
        apply(1'b0, 1'b0, 1'b0, ALU_AND);
        for (int i = 0; i < 32; i++) tick();
        check("wrap.pc", 32'(dut.pc), 32'd0);
        for (int i = 0; i < 7; i++) tick();
        check("midrst.pc7", 32'(dut.pc), 32'd7);
        set_imem(7, 32'hAC22000A);
        set_rf(2, 32'hCAFEF00D);
        apply(1'b1, 1'b0, 1'b1, ALU_ADD);
        model_outputs(e_rd1, e_rd2, e_alu, e_rdd, e_wm, rt, addr);
        tick();
        check("midrst.pc0", 32'(dut.pc), 32'd0);
        check("midrst.store", dut.u_dmem.dmem_mem[addr], 32'hCAFEF00D);

        // Randomized run against the model
        for (int i = 0; i < 32; i++) begin
            set_imem(i, $urandom);
            set_rf(i, ($urandom % 4 == 0) ? 32'($urandom % 64) : $urandom);
            set_dmem(i, $urandom);
        end
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 25) == 0, 1'($urandom), 1'($urandom), 3'($urandom));
            check_model("rnd");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
